// File: rtl/dfe_adapt_ctrl_pkg.sv
// Shared types and widths for the DFE sign-sign LMS adaptation controller.
package dfe_adapt_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRAIN  = 2'd1,
        S_UPDATE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    localparam int X_W    = 8;   // input / training sample, signed Q2.5
    localparam int ERR_W  = 9;   // equalizer output and error, signed Q2.6
    localparam int COEF_W = 12;  // coefficient delta width
    localparam int ADDR_W = 5;   // tap index width
    localparam int CNT_W  = 10;  // training sample counter

endpackage

// File: rtl/dfe_err_calc.sv
// Training error e = reference - equalizer output, aligned to Q2.6 and saturated to 9 bits.
// Purely combinational; the controller registers the result on sample acceptance.
module dfe_err_calc
    import dfe_adapt_ctrl_pkg::*;
(
    input  logic [X_W-1:0]   i_traindata,
    input  logic [ERR_W-1:0] i_ry,
    output logic [ERR_W-1:0] o_err,
    output logic             o_sign
);

    logic [ERR_W:0] diff;

    // Q2.5 -> Q2.6 by appending a zero LSB, one guard bit for the subtraction.
    assign diff = {i_traindata[X_W-1], i_traindata, 1'b0} - {i_ry[ERR_W-1], i_ry};

    always_comb begin
        o_err = diff[ERR_W-1:0];
        if (diff[ERR_W] != diff[ERR_W-1]) begin
            o_err = {diff[ERR_W], {(ERR_W-1){~diff[ERR_W]}}};
        end
    end

    assign o_sign = o_err[ERR_W-1];

endmodule

// File: rtl/dfe_adapt_ctrl.sv
// Sign-sign LMS coefficient adaptation controller for a DFE; all state on the falling clock edge.
// One sample per TRAIN/RUN acceptance; each training sample triggers an NFF+NFB-cycle tap sweep.
module dfe_adapt_ctrl
    import dfe_adapt_ctrl_pkg::*;
#(
    parameter int                        NFF       = 17,
    parameter int                        NFB       = 8,
    parameter int                        TRAIN_LEN = 64,
    parameter logic signed [COEF_W-1:0]  STEP      = 12'sd1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     data_en,
    output logic                     o_ready,
    input  logic [X_W-1:0]           i_x,
    input  logic [X_W-1:0]           i_traindata,
    input  logic [ERR_W-1:0]         i_ry,
    output logic                     status,
    output logic                     flag,
    output logic                     o_cwe,
    output logic                     o_csel,
    output logic [ADDR_W-1:0]        o_caddr,
    output logic signed [COEF_W-1:0] o_cdelta,
    output logic [ERR_W-1:0]         o_err,
    output logic                     o_busy
);

    localparam int NTAP = NFF + NFB;
    localparam int TW   = $clog2(NTAP);
    localparam logic [TW-1:0]    LAST_TAP = TW'(NTAP - 1);
    localparam logic [TW-1:0]    FF_TAPS  = TW'(NFF);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(TRAIN_LEN);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]    tap_q, tap_d;
    logic [NFF-1:0]   ff_hist_q, ff_hist_d;
    logic [NFB-1:0]   fb_hist_q, fb_hist_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             esign_q, esign_d;

    logic [ERR_W-1:0] calc_err;
    logic             calc_sign;
    logic             accept;
    logic             is_fb;
    logic [TW-1:0]    tap_addr;
    logic [NTAP-1:0]  hist_all;
    logic             unused_x;

    dfe_err_calc u_err_calc (
        .i_traindata (i_traindata),
        .i_ry        (i_ry),
        .o_err       (calc_err),
        .o_sign      (calc_sign)
    );

    assign unused_x = ^i_x[X_W-2:0];
    assign o_ready  = (state_q == S_TRAIN) || (state_q == S_RUN);
    assign o_busy   = (state_q != S_IDLE);
    assign o_err    = err_q;
    assign accept   = data_en && o_ready;

    // Tap index walks feed-forward taps first, then feedback taps.
    assign hist_all = {fb_hist_q, ff_hist_q};
    assign is_fb    = (tap_q >= FF_TAPS);
    assign tap_addr = is_fb ? (tap_q - FF_TAPS) : tap_q;

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tap_q     <= '0;
            ff_hist_q <= '0;
            fb_hist_q <= '0;
            err_q     <= '0;
            esign_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tap_q     <= tap_d;
            ff_hist_q <= ff_hist_d;
            fb_hist_q <= fb_hist_d;
            err_q     <= err_d;
            esign_q   <= esign_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tap_d     = tap_q;
        ff_hist_d = ff_hist_q;
        fb_hist_d = fb_hist_q;
        err_d     = err_q;
        esign_d   = esign_q;
        o_cwe     = 1'b0;
        o_csel    = 1'b0;
        o_caddr   = '0;
        o_cdelta  = '0;
        status    = 1'b0;
        flag      = 1'b0;

        // Accepted samples always refresh the error and sign histories, in TRAIN and RUN alike.
        if (accept) begin
            err_d     = calc_err;
            esign_d   = calc_sign;
            ff_hist_d = {ff_hist_q[NFF-2:0], i_x[X_W-1]};
            fb_hist_d = {fb_hist_q[NFB-2:0], i_traindata[X_W-1]};
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_TRAIN;
                    cnt_d     = '0;
                    ff_hist_d = '0;
                    fb_hist_d = '0;
                end
            end
            S_TRAIN: begin
                if (accept) begin
                    cnt_d   = cnt_q + 1'b1;
                    tap_d   = '0;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                // A zero error carries no direction, so the whole sweep writes nothing.
                if (err_q != '0) begin
                    o_cwe    = 1'b1;
                    o_csel   = is_fb;
                    o_caddr  = ADDR_W'(tap_addr);
                    o_cdelta = (esign_q == hist_all[tap_q]) ? STEP : -STEP;
                end
                if (tap_q == LAST_TAP) begin
                    tap_d   = '0;
                    state_d = (cnt_q == CNT_END) ? S_RUN : S_TRAIN;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            S_RUN: begin
                status = 1'b1;
                flag   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/dfe_adapt_ctrl.md
DFE_ADAPT_CTRL -- requirements
Module: dfe_adapt_ctrl

Interface
REQ-001 SHALL have parameter NFF, 17, feed-forward tap count.
REQ-002 SHALL have parameter NFB, 8, feedback tap count.
REQ-003 SHALL have parameter TRAIN_LEN, 64, training samples before switching to data mode (1..1023).
REQ-004 SHALL have parameter STEP, 12'sd1, signed magnitude of one coefficient adjustment.
REQ-005 SHALL have ports: clock  in  1  sole clock; reset  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: start  in  1  pulse, begin training from IDLE; data_en  in  1  sample valid; o_ready  out  1  sample accepted when data_en && o_ready.
REQ-007 SHALL have ports: i_x  in  8  equalizer input sample, signed Q2.5; i_traindata  in  8  training reference, signed Q2.5; i_ry  in  9  equalizer output, signed Q2.6.
REQ-008 SHALL have ports: status  out  1  0=training select, 1=raw-data select; flag  out  1  1 once training complete.
REQ-009 SHALL have ports: o_cwe  out  1  coefficient write strobe; o_csel  out  1  0=feed-forward, 1=feedback; o_caddr  out  5  tap index; o_cdelta  out  12  signed delta to add to addressed coefficient.
REQ-010 SHALL have ports: o_err  out  9  last error, signed Q2.6; o_busy  out  1  high outside IDLE.

Function
REQ-011 SHALL update all state on the falling edge of clock.
REQ-012 SHALL implement FSM states IDLE, TRAIN, UPDATE, RUN.
REQ-013 IDLE: o_ready=0; start -> TRAIN, clears sample counter and sign histories.
REQ-014 TRAIN: o_ready=1; on accepted sample capture e = ({i_traindata,1'b0}) - i_ry in 10 bits, saturate to 9-bit signed, store in o_err, shift sign(i_x) into NFF-deep history and sign(i_traindata) into NFB-deep decision history, increment counter, go UPDATE.
REQ-015 UPDATE: o_ready=0; sweep NFF feed-forward taps (o_csel=0, addr 0..NFF-1) then NFB feedback taps (o_csel=1, addr 0..NFB-1), one tap per cycle, NFF+NFB cycles total.
REQ-016 Each UPDATE cycle: o_cdelta = +STEP when sign(e) equals the tap's history sign, else -STEP (sign-sign LMS); o_cwe=1 unless e==0, then o_cwe=0 for the whole sweep.
REQ-017 End of sweep: counter==TRAIN_LEN -> RUN, else -> TRAIN.
REQ-018 RUN: status=1, flag=1, o_ready=1, o_cwe=0; histories still shift, o_err still updates; no coefficient writes; leaves only by reset.
REQ-019 start outside IDLE SHALL be ignored; data_en while o_ready=0 SHALL be ignored (not queued).
REQ-020 status SHALL be 0 in IDLE, TRAIN, UPDATE.
REQ-021 Sample-to-first-write latency SHALL be 1 cycle; next sample acceptable NFF+NFB cycles after that.
REQ-022 o_caddr, o_csel, o_cdelta SHALL be 0 when o_cwe=0.

Reset
REQ-023 reset low SHALL asynchronously force IDLE, counter 0, histories 0, and all outputs 0, including mid-sweep (no partial-sweep completion).
REQ-024 Release of reset SHALL take effect on the next falling clock edge.

Structure
REQ-025 Shared package SHALL hold the FSM state encoding, sample/error widths (8, 9), and coefficient width (12).
REQ-026 One sub-module dfe_err_calc SHALL compute the saturated error and its sign combinationally.
REQ-027 Histories SHALL be shift registers of 1-bit signs; no multipliers in this block.

Verification
REQ-028 Reset then start, no data_en -> stays TRAIN, o_ready=1, o_cwe=0, status=0.
REQ-029 TRAIN, i_traindata=8'h20, i_ry=9'h000, i_x=8'h10 -> o_err=9'h040; next cycle o_cwe=1, o_csel=0, o_caddr=0, o_cdelta=+1; 25 writes, last o_csel=1, o_caddr=7.
REQ-030 i_traindata=8'h7F, i_ry=9'h100 -> o_err saturates to 9'h0FF.
REQ-031 i_traindata=8'h10, i_ry=9'h020 -> e=0, 25 cycles with o_cwe=0, then TRAIN.
REQ-032 TRAIN_LEN=2, two samples -> after second sweep status=1, flag=1, further samples give o_cwe=0.
REQ-033 reset low at sweep cycle 10 -> immediate IDLE, all outputs 0; data_en during UPDATE -> no effect on counter.
